// File: rtl/pc_update_unit_if.sv
// Bus between the control path and the PC stage: control/offset inputs plus
// PC, redirect and status outputs.
interface pc_update_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic             busywait;
    logic             jump;
    logic             branch_eq;
    logic             branch_ne;
    logic             zero;
    logic [31:0]      shifted_offset;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             redirect;
    logic             stalled;
    logic             decode_err;
    logic [CNT_W-1:0] retired_count;

    modport master (
        output busywait, jump, branch_eq, branch_ne, zero, shifted_offset,
        input  pc, pc_plus4, redirect, stalled, decode_err, retired_count
    );

    modport slave (
        input  busywait, jump, branch_eq, branch_ne, zero, shifted_offset,
        output pc, pc_plus4, redirect, stalled, decode_err, retired_count
    );
endinterface

// File: rtl/pc_update_unit.sv
// Program-counter stage: PC register, PC+4 / branch-target adders, next-PC
// selection, memory-stall freeze and a retired-instruction counter.
module pc_update_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    pc_update_unit_if.slave  bus
);

    typedef enum logic [1:0] {StBoot, StRun, StStall} state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             derr_q, derr_d;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        dual_branch;
    logic        take;
    logic        retire;

    assign pc_plus4    = pc_q + 32'd4;
    assign target      = pc_plus4 + bus.shifted_offset;
    // Both branch kinds at once is a malformed decode: fall through unless JUMP.
    assign dual_branch = bus.branch_eq & bus.branch_ne & ~bus.jump;
    assign take        = bus.jump |
                         (~dual_branch & ((bus.branch_eq & bus.zero) |
                                          (bus.branch_ne & ~bus.zero)));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        derr_d  = derr_q;
        retire  = 1'b0;

        unique case (state_q)
            StBoot: state_d = StRun;
            StRun: begin
                if (bus.busywait) begin
                    state_d = StStall;
                end else begin
                    retire = 1'b1;
                end
            end
            StStall: begin
                if (!bus.busywait) begin
                    retire  = 1'b1;
                    state_d = StRun;
                end
            end
            default: state_d = StBoot;
        endcase

        if (retire) begin
            pc_d    = take ? target : pc_plus4;
            count_d = count_q + 1'b1;
            if (dual_branch) begin
                derr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StBoot;
            pc_q    <= RESET_VECTOR;
            count_q <= '0;
            derr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            derr_q  <= derr_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus4      = pc_plus4;
    assign bus.redirect      = take;
    assign bus.stalled       = (state_q == StStall);
    assign bus.decode_err    = derr_q;
    assign bus.retired_count = count_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed-vector bench: the driver queues hand-computed expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_pc_update_unit;

    logic clk;
    logic reset;

    pc_update_unit_if #(.CNT_W(16)) bus ();

    pc_update_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .CNT_W       (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        busy;
        logic        jmp;
        logic        beq;
        logic        bne;
        logic        zero;
        logic [31:0] off;
        logic [31:0] pc;
        logic        redir;
        logic        stall;
        logic        derr;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t expq[$];
    int   vectors_applied = 0;
    int   miscompares     = 0;

    task automatic v(input logic rst, input logic busy, input logic jmp, input logic beq,
                     input logic bne, input logic zero, input logic [31:0] off,
                     input logic [31:0] pc, input logic redir, input logic stall,
                     input logic derr, input logic [15:0] cnt);
        vec_t e;
        e.rst = rst; e.busy = busy; e.jmp = jmp; e.beq = beq; e.bne = bne; e.zero = zero;
        e.off = off; e.pc = pc; e.redir = redir; e.stall = stall; e.derr = derr; e.cnt = cnt;
        vecs.push_back(e);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: outputs are stable by the falling edge.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            vec_t e;
            logic [31:0] exp_p4;
            e      = expq.pop_front();
            exp_p4 = e.pc + 32'd4;
            vectors_applied++;
            chk32($sformatf("v%0d pc", vectors_applied - 1), bus.pc, e.pc);
            chk32($sformatf("v%0d pc_plus4", vectors_applied - 1), bus.pc_plus4, exp_p4);
            chk32($sformatf("v%0d redirect", vectors_applied - 1),
                  {31'd0, bus.redirect}, {31'd0, e.redir});
            chk32($sformatf("v%0d stalled", vectors_applied - 1),
                  {31'd0, bus.stalled}, {31'd0, e.stall});
            chk32($sformatf("v%0d decode_err", vectors_applied - 1),
                  {31'd0, bus.decode_err}, {31'd0, e.derr});
            chk32($sformatf("v%0d retired_count", vectors_applied - 1),
                  {16'd0, bus.retired_count}, {16'd0, e.cnt});
        end
    end

    initial begin
        int budget;
        reset              = 1'b0;
        bus.busywait       = 1'b0;
        bus.jump           = 1'b0;
        bus.branch_eq      = 1'b0;
        bus.branch_ne      = 1'b0;
        bus.zero           = 1'b0;
        bus.shifted_offset = 32'd0;

        //  rst bsy jmp beq bne zro offset         exp pc         rdr stl der cnt
        v(0, 0, 0, 0, 0, 0, 32'h0,          32'h0000_0000, 0, 0, 0, 16'd0);  // in reset
        v(1, 1, 0, 0, 0, 0, 32'h0,          32'h0000_0000, 0, 0, 0, 16'd0);  // BOOT ignores busy
        v(1, 0, 0, 0, 0, 0, 32'h0,          32'h0000_0000, 0, 0, 0, 16'd0);
        v(1, 0, 0, 0, 0, 0, 32'h0,          32'h0000_0004, 0, 0, 0, 16'd1);
        v(1, 0, 0, 0, 0, 0, 32'h0,          32'h0000_0008, 0, 0, 0, 16'd2);
        v(1, 0, 0, 0, 0, 0, 32'h0,          32'h0000_000C, 0, 0, 0, 16'd3);
        v(1, 0, 0, 1, 0, 1, 32'hFFFF_FFF8,  32'h0000_0010, 1, 0, 0, 16'd4);  // BEQ taken, -8
        v(1, 0, 0, 0, 0, 0, 32'h0,          32'h0000_000C, 0, 0, 0, 16'd5);
        v(1, 0, 0, 1, 0, 0, 32'hFFFF_FFF8,  32'h0000_0010, 0, 0, 0, 16'd6);  // BEQ not taken
        v(1, 0, 1, 0, 0, 0, 32'h0000_0008,  32'h0000_0014, 1, 0, 0, 16'd7);
        v(1, 0, 1, 0, 1, 1, 32'h0000_0040,  32'h0000_0020, 1, 0, 0, 16'd8);  // JUMP beats BNE
        v(1, 1, 0, 0, 1, 0, 32'h0000_0010,  32'h0000_0064, 1, 0, 0, 16'd9);  // stall begins
        v(1, 1, 0, 0, 1, 0, 32'h0000_0010,  32'h0000_0064, 1, 1, 0, 16'd9);
        v(1, 1, 0, 0, 1, 0, 32'h0000_0010,  32'h0000_0064, 1, 1, 0, 16'd9);
        v(1, 0, 0, 0, 1, 0, 32'h0000_0010,  32'h0000_0064, 1, 1, 0, 16'd9);  // release
        v(1, 0, 1, 0, 0, 0, 32'hFFFF_FF80,  32'h0000_0078, 1, 0, 0, 16'd10);
        v(1, 0, 0, 0, 0, 0, 32'h0,          32'hFFFF_FFFC, 0, 0, 0, 16'd11); // PC wraps
        v(1, 0, 0, 1, 1, 1, 32'h0000_0040,  32'h0000_0000, 0, 0, 0, 16'd12); // dual branch
        v(1, 0, 0, 0, 0, 0, 32'h0,          32'h0000_0004, 0, 0, 1, 16'd13);
        v(1, 1, 1, 0, 0, 0, 32'h0000_0100,  32'h0000_0008, 1, 0, 1, 16'd14);
        v(0, 1, 1, 0, 0, 0, 32'h0000_0100,  32'h0000_0008, 1, 1, 1, 16'd14); // reset in stall
        v(1, 0, 0, 0, 0, 0, 32'h0,          32'h0000_0000, 0, 0, 0, 16'd0);
        v(1, 0, 0, 0, 0, 0, 32'h0,          32'h0000_0000, 0, 0, 0, 16'd0);
        v(1, 0, 0, 0, 0, 0, 32'h0,          32'h0000_0004, 0, 0, 0, 16'd1);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            reset              = vecs[i].rst;
            bus.busywait       = vecs[i].busy;
            bus.jump           = vecs[i].jmp;
            bus.branch_eq      = vecs[i].beq;
            bus.branch_ne      = vecs[i].bne;
            bus.zero           = vecs[i].zero;
            bus.shifted_offset = vecs[i].off;
            expq.push_back(vecs[i]);
        end

        budget = 0;
        while (expq.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #1;
        if (expq.size() > 0 || vectors_applied != vecs.size()) begin
            miscompares++;
            $display("FAIL drain: %0d vectors checked, expected %0d", vectors_applied,
                     vecs.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
